// File: rtl/umi_endpoint.sv
// UMI responder: turns request packets into local register/memory accesses
// and returns read data / write acks as UMI response packets.
module umi_endpoint #(
  parameter int AW = 64,
  parameter int CW = 32,
  parameter int DW = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          udev_req_valid,
  input  logic [CW-1:0] udev_req_cmd,
  input  logic [AW-1:0] udev_req_dstaddr,
  input  logic [AW-1:0] udev_req_srcaddr,
  input  logic [DW-1:0] udev_req_data,
  output logic          udev_req_ready,
  output logic          udev_resp_valid,
  output logic [CW-1:0] udev_resp_cmd,
  output logic [AW-1:0] udev_resp_dstaddr,
  output logic [AW-1:0] udev_resp_srcaddr,
  output logic [DW-1:0] udev_resp_data,
  input  logic          udev_resp_ready,
  output logic          loc_req,
  output logic          loc_write,
  output logic [AW-1:0] loc_addr,
  output logic [DW-1:0] loc_wrdata,
  output logic [2:0]    loc_size,
  input  logic          loc_ack,
  input  logic [DW-1:0] loc_rddata
);

  localparam logic [4:0] REQ_RD      = 5'h01;
  localparam logic [4:0] REQ_WR      = 5'h03;
  localparam logic [4:0] REQ_WRPOSTED = 5'h05;
  localparam logic [4:0] RESP_RD     = 5'h02;
  localparam logic [4:0] RESP_WR     = 5'h04;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        r_state;
  logic [CW-3:0] r_cmd;
  logic          r_resp_valid;
  logic [CW-1:0] r_resp_cmd;
  logic [AW-1:0] r_resp_dst;
  logic [AW-1:0] r_resp_src;
  logic [DW-1:0] r_resp_data;
  logic          r_loc_req;
  logic          r_loc_write;
  logic [AW-1:0] r_loc_addr;
  logic [DW-1:0] r_loc_wrdata;
  logic [2:0]    r_loc_size;

  logic [4:0] w_op;
  logic       w_legal;
  logic       w_unused;

  assign w_op     = udev_req_cmd[4:0];
  assign w_legal  = (w_op == REQ_RD) || (w_op == REQ_WR) || (w_op == REQ_WRPOSTED);
  // Incoming status bits are always overwritten in the response.
  assign w_unused = ^udev_req_cmd[CW-1:CW-2];

  // Gated by reset so ready is low while reset is held and high the first
  // cycle after it drops.
  assign udev_req_ready    = (r_state == IDLE) && !reset;
  assign udev_resp_valid   = r_resp_valid;
  assign udev_resp_cmd     = r_resp_cmd;
  assign udev_resp_dstaddr = r_resp_dst;
  assign udev_resp_srcaddr = r_resp_src;
  assign udev_resp_data    = r_resp_data;
  assign loc_req           = r_loc_req;
  assign loc_write         = r_loc_write;
  assign loc_addr          = r_loc_addr;
  assign loc_wrdata        = r_loc_wrdata;
  assign loc_size          = r_loc_size;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cmd        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_cmd   <= '0;
      r_resp_dst   <= '0;
      r_resp_src   <= '0;
      r_resp_data  <= '0;
      r_loc_req    <= 1'b0;
      r_loc_write  <= 1'b0;
      r_loc_addr   <= '0;
      r_loc_wrdata <= '0;
      r_loc_size   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (udev_req_valid) begin
            r_cmd      <= udev_req_cmd[CW-3:0];
            r_resp_dst <= udev_req_srcaddr;
            r_resp_src <= udev_req_dstaddr;
            if (w_legal) begin
              r_state      <= ACCESS;
              r_loc_req    <= 1'b1;
              r_loc_write  <= (w_op != REQ_RD);
              r_loc_addr   <= udev_req_dstaddr;
              r_loc_wrdata <= udev_req_data;
              r_loc_size   <= udev_req_cmd[7:5];
            end else begin
              // Unknown opcode: error write-ack, local port untouched.
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_cmd   <= {2'b10, udev_req_cmd[CW-3:5], RESP_WR};
              r_resp_data  <= '0;
            end
          end
        end
        ACCESS: begin
          if (loc_ack) begin
            r_loc_req <= 1'b0;
            if (r_cmd[4:0] == REQ_RD) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_cmd   <= {2'b00, r_cmd[CW-3:5], RESP_RD};
              r_resp_data  <= loc_rddata;
            end else if (r_cmd[4:0] == REQ_WR) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_cmd   <= {2'b00, r_cmd[CW-3:5], RESP_WR};
              r_resp_data  <= '0;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        RESP: begin
          if (udev_resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/umi_endpoint.md
# umi_endpoint

Single-clock UMI responder that terminates request traffic arriving from a UMI FIFO output and turns it into accesses on a simple local register/memory port. It returns read data and write acknowledgements as UMI response packets on a separate response channel. It sits on the device side of a link, after the clock-domain crossing FIFO, and is the responder that pairs with the host-side initiator.

## Interface
Parameters:
- AW, 64, address width
- CW, 32, command width
- DW, 256, data width (local port width)

Ports:
- clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- udev_req_valid  input  1  request valid
- udev_req_cmd  input  CW  request command
- udev_req_dstaddr  input  AW  local target address
- udev_req_srcaddr  input  AW  return address
- udev_req_data  input  DW  write data
- udev_req_ready  output  1  request accept
- udev_resp_valid  output  1  response valid
- udev_resp_cmd  output  CW  response command
- udev_resp_dstaddr  output  AW  response destination
- udev_resp_srcaddr  output  AW  response source
- udev_resp_data  output  DW  read data
- udev_resp_ready  input  1  response accept
- loc_req  output  1  local access strobe
- loc_write  output  1  1 = write, 0 = read
- loc_addr  output  AW  local address
- loc_wrdata  output  DW  local write data
- loc_size  output  3  log2 bytes of access
- loc_ack  input  1  local access complete (reads and writes)
- loc_rddata  input  DW  read data, valid with loc_ack

## Operation
- Command fields: cmd[4:0] opcode, cmd[7:5] size, cmd[31:30] status; other bits copied request to response.
- Opcodes: 5'h01 REQ_RD, 5'h03 REQ_WR, 5'h05 REQ_WRPOSTED, 5'h02 RESP_RD, 5'h04 RESP_WR.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: udev_req_ready=1. On valid&ready, register cmd/addresses/data.
  - RD, WR, or WRPOSTED -> ACCESS.
  - Any other opcode -> RESP with error: opcode RESP_WR, status 2'b10, no local access.
- ACCESS: loc_req=1 with loc_write, loc_addr, loc_wrdata and loc_size held stable until loc_ack. On loc_ack:
  - RD: capture loc_rddata -> RESP.
  - WR -> RESP.
  - WRPOSTED -> IDLE, with no response.
- RESP: udev_resp_valid=1. All response fields are held stable until udev_resp_ready, then -> IDLE.
- Response fields:
  - dstaddr = request srcaddr; srcaddr = request dstaddr.
  - opcode RESP_RD for a read, RESP_WR for a write; status 2'b00 on success.
  - data = captured read data for reads, else zero.
- One transaction outstanding; no pipelining.
- loc_ack outside ACCESS is ignored.

## Timing
- Reset values: udev_req_ready=0 during reset, 1 the first cycle after reset deasserts; udev_resp_valid=0; loc_req=0; loc_write=0; all data, address and cmd outputs 0; FSM=IDLE.
- Request accepted at edge N: loc_req high from cycle N+1.
- loc_ack sampled at edge M: loc_req low from M+1; udev_resp_valid high from M+1 (RD/WR); udev_req_ready high from M+1 (WRPOSTED).
- loc_ack in the same cycle loc_req first rises is legal. Minimum RD/WR turnaround is 3 cycles from accept to next accept with resp_ready held high.
- Response taken at edge K: udev_resp_valid low and udev_req_ready high from K+1.
- Request and response channels never both handshake in the same cycle. udev_req_ready is low in ACCESS and RESP.
- Reset asserted mid-operation: at the next edge, drop the transaction, deassert loc_req and udev_resp_valid, and return to IDLE. A loc_ack arriving after that is ignored.

## Test plan
- Read: REQ_RD dstaddr=0x100, srcaddr=0xABC0, size=2; loc_ack after 3 cycles with rddata=0xDEADBEEF -> one response: RESP_RD, dstaddr=0xABC0, srcaddr=0x100, data=0xDEADBEEF, status 0.
- Write: REQ_WR addr=0x20, data=0x55 -> loc_write=1, loc_addr=0x20, loc_wrdata=0x55; after loc_ack, one RESP_WR with data=0.
- Posted write: REQ_WRPOSTED -> local write occurs, udev_resp_valid never asserts, udev_req_ready returns 1 cycle after loc_ack.
- Backpressure: hold udev_resp_ready=0 for 10 cycles -> response fields stable, udev_req_ready=0 throughout, a second request is not accepted until after the handshake.
- Illegal opcode 5'h1F -> no loc_req, one RESP_WR with cmd[31:30]=2'b10.
- Reset during ACCESS (loc_ack withheld) -> loc_req=0 next cycle; a late loc_ack produces no response; the next REQ_RD completes normally.
